// File: rtl/state_serializer.sv
// Serialises a 1600-bit permutation state into eight 200-bit beats; beat 0 follows the load edge, one beat per accepted cycle.
// stopout holds the current beat in place; ready is low for the whole block, so a new load waits for the IDLE cycle.
module state_serializer (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pushin,
  input  logic [4:0][4:0][63:0]  din,
  input  logic                   stopout,
  output logic                   ready,
  output logic                   pushout,
  output logic [2:0]             doutix,
  output logic [199:0]           dout
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [2:0]          r_cnt;
  logic [1599:0]       r_hold;
  logic [1599:0]       w_flat;
  logic [7:0][199:0]   w_chunks;
  logic                w_load;
  logic                w_accept;
  logic                w_last;

  // Lane L = x + 5*y occupies flattened bits [64L+63:64L]; packed din order does not match this.
  always_comb begin
    w_flat = '0;
    for (int x = 0; x < 5; x++) begin
      for (int y = 0; y < 5; y++) begin
        w_flat[64*(x+5*y) +: 64] = din[x][y];
      end
    end
  end

  assign w_chunks = r_hold;
  assign w_load   = (r_state == IDLE) && pushin;
  assign w_accept = (r_state == SEND) && !stopout;
  assign w_last   = w_accept && (r_cnt == 3'd7);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (w_load) w_next_state = SEND;
      SEND:    if (w_last) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt  <= 3'd0;
      r_hold <= '0;
    end else if (w_load) begin
      r_cnt  <= 3'd0;
      r_hold <= w_flat;
    end else if (w_accept) begin
      // Wraps 7->0 exactly when the FSM drops back to IDLE.
      r_cnt  <= r_cnt + 3'd1;
    end
  end

  always_comb begin
    ready   = 1'b1;
    pushout = 1'b0;
    doutix  = 3'd0;
    dout    = '0;
    if (r_state == SEND) begin
      ready   = 1'b0;
      pushout = 1'b1;
      doutix  = r_cnt;
      dout    = w_chunks[r_cnt];
    end
  end

endmodule

// File: tb/tb_state_serializer.sv
// Directed bench for state_serializer: reset, streaming, stall, load-ignore, mid-block reset, back-to-back, round trip.
module tb_state_serializer;

  logic                  clk;
  logic                  reset;
  logic                  pushin;
  logic [4:0][4:0][63:0] din;
  logic                  stopout;
  logic                  ready;
  logic                  pushout;
  logic [2:0]            doutix;
  logic [199:0]          dout;

  int n_cmp = 0;
  int n_bad = 0;

  state_serializer dut (
    .clk     (clk),
    .reset   (reset),
    .pushin  (pushin),
    .din     (din),
    .stopout (stopout),
    .ready   (ready),
    .pushout (pushout),
    .doutix  (doutix),
    .dout    (dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Flattened bit 64*(x+5y)+z is din[x][y][z].
  function automatic logic [1599:0] flat(input logic [4:0][4:0][63:0] s);
    logic [1599:0] f;
    f = '0;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        for (int z = 0; z < 64; z++)
          f[64*(x+5*y)+z] = s[x][y][z];
    return f;
  endfunction

  function automatic logic [4:0][4:0][63:0] rand_state();
    logic [1599:0] v;
    for (int i = 0; i < 50; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; pushin = 1'b1; stopout = 1'b1; din = '1;
    step(); step();
    n_cmp++; if (ready !== 1'b1)   begin n_bad++; $display("FAIL reset_ready: got %b expected 1", ready); end
    n_cmp++; if (pushout !== 1'b0) begin n_bad++; $display("FAIL reset_pushout: got %b expected 0", pushout); end
    n_cmp++; if (doutix !== 3'd0)  begin n_bad++; $display("FAIL reset_doutix: got %0d expected 0", doutix); end
    n_cmp++; if (dout !== 200'd0)  begin n_bad++; $display("FAIL reset_dout: got %h expected 0", dout); end
    reset = 1'b1; pushin = 1'b0; stopout = 1'b0;
    step();
    n_cmp++; if (pushout !== 1'b0) begin n_bad++; $display("FAIL reset_no_capture: got %b expected 0", pushout); end
  endtask

  task automatic test_basic();
    logic [1599:0] exp;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        din[x][y] = {8'(x), 8'(y), 48'h0};
    exp = flat(din);
    pushin = 1'b1; step(); pushin = 1'b0;
    n_cmp++; if (dout[63:0] !== 64'h0) begin n_bad++; $display("FAIL basic_lane0: got %h expected 0", dout[63:0]); end
    n_cmp++; if (dout[127:64] !== 64'h0100_0000_0000_0000) begin n_bad++; $display("FAIL basic_lane1: got %h expected 0100000000000000", dout[127:64]); end
    n_cmp++; if (dout[199:192] !== 8'h00) begin n_bad++; $display("FAIL basic_lane3_lo: got %h expected 00", dout[199:192]); end
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (pushout !== 1'b1) begin n_bad++; $display("FAIL basic_pushout beat %0d: got %b expected 1", k, pushout); end
      n_cmp++; if (ready !== 1'b0)   begin n_bad++; $display("FAIL basic_ready beat %0d: got %b expected 0", k, ready); end
      n_cmp++; if (doutix !== 3'(k)) begin n_bad++; $display("FAIL basic_doutix: got %0d expected %0d", doutix, k); end
      n_cmp++; if (dout !== exp[200*k +: 200]) begin n_bad++; $display("FAIL basic_dout beat %0d: got %h expected %h", k, dout, exp[200*k +: 200]); end
      step();
    end
    n_cmp++; if (pushout !== 1'b0) begin n_bad++; $display("FAIL basic_end_pushout: got %b expected 0", pushout); end
    n_cmp++; if (ready !== 1'b1)   begin n_bad++; $display("FAIL basic_end_ready: got %b expected 1", ready); end
  endtask

  task automatic test_stall();
    int e = 0, stalls = 0, total = 0, twos = 0, cyc = 0;
    din = '1;
    pushin = 1'b1; step(); pushin = 1'b0;
    while (pushout === 1'b1 && cyc < 40) begin
      total++;
      if (doutix == 3'd2) twos++;
      n_cmp++; if (doutix !== 3'(e)) begin n_bad++; $display("FAIL stall_doutix: got %0d expected %0d", doutix, e); end
      n_cmp++; if (dout !== {200{1'b1}}) begin n_bad++; $display("FAIL stall_dout: got %h expected all ones", dout); end
      if (e == 2 && stalls < 3) begin stopout = 1'b1; stalls++; end
      else begin stopout = 1'b0; e++; end
      step(); cyc++;
    end
    stopout = 1'b0;
    n_cmp++; if (total != 11) begin n_bad++; $display("FAIL stall_total: got %0d expected 11", total); end
    n_cmp++; if (twos != 4)   begin n_bad++; $display("FAIL stall_hold_cycles: got %0d expected 4", twos); end
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL stall_end_ready: got %b expected 1", ready); end
  endtask

  task automatic test_ignore_push();
    logic [4:0][4:0][63:0] a, b;
    logic [1599:0] exp;
    a = rand_state(); b = rand_state(); exp = flat(a);
    din = a; pushin = 1'b1; step();
    din = b;
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (dout !== exp[200*k +: 200]) begin n_bad++; $display("FAIL ignore_dout beat %0d: got %h expected %h", k, dout, exp[200*k +: 200]); end
      if (k == 7) pushin = 1'b0;
      step();
    end
    n_cmp++; if (pushout !== 1'b0) begin n_bad++; $display("FAIL ignore_end_pushout: got %b expected 0", pushout); end
    step();
    n_cmp++; if (pushout !== 1'b0) begin n_bad++; $display("FAIL ignore_no_reload: got %b expected 0", pushout); end
  endtask

  task automatic test_mid_reset();
    int extra = 0;
    din = rand_state();
    pushin = 1'b1; step(); pushin = 1'b0;
    repeat (4) step();
    n_cmp++; if (doutix !== 3'd4) begin n_bad++; $display("FAIL midrst_at_beat: got %0d expected 4", doutix); end
    reset = 1'b0; step();
    n_cmp++; if (pushout !== 1'b0) begin n_bad++; $display("FAIL midrst_pushout: got %b expected 0", pushout); end
    n_cmp++; if (doutix !== 3'd0)  begin n_bad++; $display("FAIL midrst_doutix: got %0d expected 0", doutix); end
    n_cmp++; if (dout !== 200'd0)  begin n_bad++; $display("FAIL midrst_dout: got %h expected 0", dout); end
    n_cmp++; if (ready !== 1'b1)   begin n_bad++; $display("FAIL midrst_ready: got %b expected 1", ready); end
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (pushout === 1'b1) extra++;
    end
    n_cmp++; if (extra != 0) begin n_bad++; $display("FAIL midrst_leftover_beats: got %0d expected 0", extra); end
  endtask

  task automatic test_back_to_back();
    logic [1599:0] exp;
    din = rand_state(); exp = flat(din);
    pushin = 1'b1; step();
    for (int c = 0; c < 17; c++) begin
      logic exp_po;
      int   ix;
      exp_po = (c != 8);
      ix = (c < 8) ? c : c - 9;
      n_cmp++; if (pushout !== exp_po) begin n_bad++; $display("FAIL b2b_pushout cycle %0d: got %b expected %b", c, pushout, exp_po); end
      if (c != 8) begin
        n_cmp++; if (doutix !== 3'(ix)) begin n_bad++; $display("FAIL b2b_doutix cycle %0d: got %0d expected %0d", c, doutix, ix); end
        n_cmp++; if (dout !== exp[200*ix +: 200]) begin n_bad++; $display("FAIL b2b_dout cycle %0d: got %h expected %h", c, dout, exp[200*ix +: 200]); end
      end
      if (c == 16) pushin = 1'b0;
      step();
    end
    n_cmp++; if (pushout !== 1'b0) begin n_bad++; $display("FAIL b2b_end_pushout: got %b expected 0", pushout); end
  endtask

  task automatic test_roundtrip();
    logic [1599:0] exp, rx;
    int recv = 0, cyc = 0;
    din = rand_state(); exp = flat(din); rx = '0;
    pushin = 1'b1; step(); pushin = 1'b0;
    while (pushout === 1'b1 && cyc < 100) begin
      stopout = 1'($urandom_range(0, 1));
      if (!stopout) begin
        rx[int'(doutix)*200 +: 200] = dout;
        recv++;
      end
      step(); cyc++;
    end
    stopout = 1'b0;
    n_cmp++; if (recv != 8) begin n_bad++; $display("FAIL rt_beats: got %0d expected 8", recv); end
    n_cmp++; if (rx !== exp) begin n_bad++; $display("FAIL rt_state: reassembled state differs from loaded state (low chunk got %h expected %h)", rx[199:0], exp[199:0]); end
  endtask

  initial begin
    reset = 1'b0; pushin = 1'b0; stopout = 1'b0; din = '0;
    test_reset();
    test_basic();
    test_stall();
    test_ignore_push();
    test_mid_reset();
    test_back_to_back();
    test_roundtrip();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
